// File: rtl/seq_detect_param.sv
// seq_detect_param: serial bit-pattern detector with a runtime-loadable
// PAT_W-bit pattern, overlapping/non-overlapping detection, Mealy or Moore
// match timing and a saturating match counter.
//
// Stream qualifier: en is a bit-valid strobe with no back-pressure. A bit is
// consumed on every rising clk edge where en=1 and pat_load=0. When en=0 the
// data_stream value is ignored, and the history is held so that a partial
// match survives idle gaps. pat_load takes priority over en.
module seq_detect_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             data_stream,
  input  logic             overlap,
  input  logic             moore_mode,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_value,
  output logic             match,
  output logic [CNT_W-1:0] match_count
);

  localparam int               FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  // Registered state.
  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-2:0]  hist_q;   // most recent bits, LSB newest
  logic [FILL_W-1:0] fill_q;   // number of valid bits held in hist_q
  logic              match_q;
  logic [CNT_W-1:0]  cnt_q;

  // Next-state values.
  logic [PAT_W-1:0]  pat_d;
  logic [PAT_W-2:0]  hist_d;
  logic [FILL_W-1:0] fill_d;
  logic              match_d;
  logic [CNT_W-1:0]  cnt_d;

  // Window formed by the stored history plus the bit currently presented.
  logic [PAT_W-1:0] window;
  logic             hit;

  assign window = {hist_q, data_stream};
  assign hit    = en & ~pat_load & (fill_q == FILL_MAX) & (window == pat_q);

  // State register: asynchronous active-low clear of every piece of state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q   <= PATTERN;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: pattern load flushes everything, an enabled bit shifts
  // the window, a non-overlapping hit discards the history.
  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = hit;
    cnt_d   = cnt_q;
    if (pat_load) begin
      pat_d  = pat_value;
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (en) begin
      hist_d = window[PAT_W-2:0];
      if (hit && !overlap) begin
        fill_d = '0;
      end else if (fill_q == FILL_MAX) begin
        fill_d = FILL_MAX;
      end else begin
        fill_d = fill_q + FILL_W'(1);
      end
      if (hit && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Output logic: Moore uses the registered hit, Mealy the live one.
  always_comb begin
    match       = moore_mode ? match_q : hit;
    match_count = cnt_q;
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param. A second instance with a 2-bit
// counter shares all inputs and exercises counter saturation. The reference
// model keeps the enabled bits seen since the last flush in a queue and
// compares the latest PAT_W of them with the pattern.
module tb_seq_detect_param;

  localparam int PAT_W = 4;

  logic             clk;
  logic             reset;
  logic             en;
  logic             data_stream;
  logic             overlap;
  logic             moore_mode;
  logic             pat_load;
  logic [PAT_W-1:0] pat_value;
  logic             match;
  logic [7:0]       match_count;
  logic             match_sat;
  logic [1:0]       match_count_sat;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [PAT_W-1:0] m_pat;
  logic             m_bits[$];
  int               m_cnt;
  int               m_cnt_sat;
  logic             m_hit;
  logic             exp_match;
  logic [0:0]       exp_q[$];   // registered (Moore) match expectation

  seq_detect_param #(.PAT_W(PAT_W), .PATTERN(4'b1010), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .data_stream(data_stream),
    .overlap(overlap), .moore_mode(moore_mode), .pat_load(pat_load),
    .pat_value(pat_value), .match(match), .match_count(match_count)
  );

  seq_detect_param #(.PAT_W(PAT_W), .PATTERN(4'b1010), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .data_stream(data_stream),
    .overlap(overlap), .moore_mode(moore_mode), .pat_load(pat_load),
    .pat_value(pat_value), .match(match_sat), .match_count(match_count_sat)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    reset = 1'b0; en = 1'b0; data_stream = 1'b0; overlap = 1'b0;
    moore_mode = 1'b0; pat_load = 1'b0; pat_value = '0;
  end

  task automatic model_reset();
    m_pat = 4'b1010;
    m_bits.delete();
    m_cnt = 0;
    m_cnt_sat = 0;
    m_hit = 1'b0;
    exp_q.delete();
    exp_q.push_back(1'b0);
  endtask

  // Does the stream seen so far, plus the bit now presented, end in the pattern?
  function automatic logic model_hit();
    logic [PAT_W-1:0] w;
    w = '0;
    if (!reset || !en || pat_load || (m_bits.size() < PAT_W - 1)) return 1'b0;
    for (int i = 0; i < PAT_W - 1; i++)
      w[PAT_W-1-i] = m_bits[m_bits.size() - (PAT_W - 1) + i];
    w[0] = data_stream;
    return (w == m_pat);
  endfunction

  // Driver: apply inputs on the falling edge and compute the expectations
  // for the cycle that is now presented.
  task automatic drive(input logic r, input logic e, input logic d, input logic ov,
                       input logic mm, input logic ld, input logic [PAT_W-1:0] pv);
    @(negedge clk);
    reset = r; en = e; data_stream = d; overlap = ov;
    moore_mode = mm; pat_load = ld; pat_value = pv;
    #1;
    if (!reset) model_reset();
    m_hit = model_hit();
    exp_match = mm ? exp_q[0] : m_hit;
  endtask

  // Advance the model across the rising edge using the inputs just sampled.
  task automatic advance();
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      if (pat_load) begin
        m_pat = pat_value;
        m_bits.delete();
        m_cnt = 0;
        m_cnt_sat = 0;
      end else if (en) begin
        m_bits.push_back(data_stream);
        if (m_hit && !overlap) m_bits.delete();
        while (m_bits.size() > PAT_W - 1) void'(m_bits.pop_front());
      end
      if (m_hit) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt_sat < 3) m_cnt_sat++;
      end
      exp_q.push_back(m_hit);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    advance();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, i[0], 1'b0, 1'b0, 1'b0, '0);
      checks++; if (match !== 1'b0) begin errors++; $display("FAIL reset_match cyc %0d got %b expected 0", i, match); end
      checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL reset_count cyc %0d got %0d expected 0", i, match_count); end
      checks++; if (match_count_sat !== 2'd0) begin errors++; $display("FAIL reset_count_sat cyc %0d got %0d expected 0", i, match_count_sat); end
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, (i == 1) ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0, '0);
      checks++; if (match !== 1'b0) begin errors++; $display("FAIL reset_first_bits cyc %0d got %b expected 0", i, match); end
      advance();
    end
  endtask

  task automatic test_nonoverlap();
    logic [7:0] bits;
    logic [7:0] seen;
    bits = 8'b10101010;
    seen = '0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, bits[7-i], 1'b0, 1'b0, 1'b0, '0);
      seen[i] = match;
      checks++; if (match !== exp_match) begin errors++; $display("FAIL nonovl_match cyc %0d got %b expected %b", i, match, exp_match); end
      checks++; if (match_count !== 8'(m_cnt)) begin errors++; $display("FAIL nonovl_count cyc %0d got %0d expected %0d", i, match_count, m_cnt); end
      advance();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    checks++; if (seen !== 8'b1000_1000) begin errors++; $display("FAIL nonovl_positions got %b expected 10001000", seen); end
    checks++; if (match_count !== 8'd2) begin errors++; $display("FAIL nonovl_total got %0d expected 2", match_count); end
    advance();
  endtask

  task automatic test_overlap();
    logic [5:0] bits;
    logic [6:0] seen;
    bits = 6'b101010;
    for (int mm = 0; mm < 2; mm++) begin
      seen = '0;
      do_reset();
      for (int i = 0; i < 7; i++) begin
        drive(1'b1, (i < 6) ? 1'b1 : 1'b0, (i < 6) ? bits[5-i] : 1'b0, 1'b1, mm[0], 1'b0, '0);
        seen[i] = match;
        checks++; if (match !== exp_match) begin errors++; $display("FAIL ovl_match mode %0d cyc %0d got %b expected %b", mm, i, match, exp_match); end
        checks++; if (match_count !== 8'(m_cnt)) begin errors++; $display("FAIL ovl_count mode %0d cyc %0d got %0d expected %0d", mm, i, match_count, m_cnt); end
        advance();
      end
      if (mm == 0) begin
        checks++; if (seen !== 7'b0101000) begin errors++; $display("FAIL ovl_mealy_positions got %b expected 0101000", seen); end
      end else begin
        checks++; if (seen !== 7'b1010000) begin errors++; $display("FAIL ovl_moore_positions got %b expected 1010000", seen); end
      end
      drive(1'b1, 1'b0, 1'b0, 1'b1, mm[0], 1'b0, '0);
      checks++; if (match_count !== 8'd2) begin errors++; $display("FAIL ovl_total mode %0d got %0d expected 2", mm, match_count); end
      advance();
    end
  endtask

  task automatic test_saturation();
    logic [11:0] bits;
    bits = 12'b1010_1010_1010;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, bits[11-i], 1'b1, 1'b0, 1'b0, '0);
      checks++; if (match_sat !== exp_match) begin errors++; $display("FAIL sat_match cyc %0d got %b expected %b", i, match_sat, exp_match); end
      checks++; if (match_count_sat !== 2'(m_cnt_sat)) begin errors++; $display("FAIL sat_count cyc %0d got %0d expected %0d", i, match_count_sat, m_cnt_sat); end
      advance();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    checks++; if (match_count_sat !== 2'd3) begin errors++; $display("FAIL sat_final got %0d expected 3", match_count_sat); end
    checks++; if (match_count !== 8'd5) begin errors++; $display("FAIL sat_wide_final got %0d expected 5", match_count); end
    advance();
  endtask

  task automatic test_gap_load();
    logic [6:0] en_v;
    logic [6:0] d_v;
    logic [7:0] bits;
    logic [7:0] seen;
    en_v = 7'b1100011;
    d_v  = 7'b1000010;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, en_v[6-i], en_v[6-i] ? d_v[6-i] : 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, '0);
      checks++; if (match !== exp_match) begin errors++; $display("FAIL gap_match cyc %0d got %b expected %b", i, match, exp_match); end
      if (i == 6) begin
        checks++; if (match !== 1'b1) begin errors++; $display("FAIL gap_last_bit got %b expected 1", match); end
      end
      advance();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1101);
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL load_match got %b expected 0", match); end
    advance();
    bits = 8'b1101_1010;
    seen = '0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, bits[7-i], 1'b0, 1'b0, 1'b0, '0);
      seen[i] = match;
      if (i == 0) begin
        checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL load_count_clear got %0d expected 0", match_count); end
      end
      checks++; if (match !== exp_match) begin errors++; $display("FAIL load_match cyc %0d got %b expected %b", i, match, exp_match); end
      advance();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    checks++; if (seen !== 8'b0000_1000) begin errors++; $display("FAIL load_positions got %b expected 00001000", seen); end
    checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL load_total got %0d expected 1", match_count); end
    advance();
  endtask

  task automatic test_async_reset();
    logic [6:0] bits;
    bits = 7'b1010_101;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, bits[6-i], 1'b0, 1'b0, 1'b0, '0);
      checks++; if (match !== exp_match) begin errors++; $display("FAIL areset_pre cyc %0d got %b expected %b", i, match, exp_match); end
      advance();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    checks++; if (match !== 1'b1) begin errors++; $display("FAIL areset_pending got %b expected 1", match); end
    #1 reset = 1'b0;
    #1;
    model_reset();
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL areset_match got %b expected 0", match); end
    checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL areset_count got %0d expected 0", match_count); end
    advance();
    bits = 7'b0101_000;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, bits[6-i], 1'b0, 1'b0, 1'b0, '0);
      checks++; if (match !== exp_match) begin errors++; $display("FAIL areset_post cyc %0d got %b expected %b", i, match, exp_match); end
      checks++; if (match !== ((i == 4) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL areset_post_fixed cyc %0d got %b", i, match); end
      advance();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 15)));
      checks++; if (match !== exp_match) begin errors++; $display("FAIL rand_match cyc %0d got %b expected %b", i, match, exp_match); end
      checks++; if (match_sat !== exp_match) begin errors++; $display("FAIL rand_match_sat cyc %0d got %b expected %b", i, match_sat, exp_match); end
      checks++; if (match_count !== 8'(m_cnt)) begin errors++; $display("FAIL rand_count cyc %0d got %0d expected %0d", i, match_count, m_cnt); end
      checks++; if (match_count_sat !== 2'(m_cnt_sat)) begin errors++; $display("FAIL rand_count_sat cyc %0d got %0d expected %0d", i, match_count_sat, m_cnt_sat); end
      advance();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_nonoverlap();
    test_overlap();
    test_saturation();
    test_gap_load();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
